// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the CPU MEM stage and an external requester.
// Fixed-latency access sequencing with a bounded-wait override so the external side cannot starve.
module dmem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_stall,
  output logic              o_cpu_done,
  output logic [DATA_W-1:0] o_cpu_rdata,
  input  logic              i_ext_req,
  input  logic              i_ext_we,
  input  logic [ADDR_W-1:0] i_ext_addr,
  input  logic [DATA_W-1:0] i_ext_wdata,
  output logic              o_ext_gnt,
  output logic              o_ext_done,
  output logic [DATA_W-1:0] o_ext_rdata,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);
  localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_BUSY_CPU = 2'd1,
    S_BUSY_EXT = 2'd2,
    S_RESP     = 2'd3
  } state_t;

  state_t           r_state;
  logic [LAT_W-1:0] r_lat_cnt;
  logic [SC_W-1:0]  r_starve_cnt;
  logic             w_ext_forced;

  // The CPU loses a contested IDLE cycle only once the external side has waited its full budget.
  assign w_ext_forced = i_ext_req && (r_starve_cnt == SC_MAX);
  assign o_cpu_stall  = i_cpu_req & ~o_cpu_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
      o_cpu_done   <= 1'b0;
      o_ext_done   <= 1'b0;
      o_ext_gnt    <= 1'b0;
      o_cpu_rdata  <= '0;
      o_ext_rdata  <= '0;
      o_mem_read   <= 1'b0;
      o_mem_write  <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
    end else begin
      o_cpu_done <= 1'b0;
      o_ext_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_cpu_req && !w_ext_forced) begin
            r_state     <= S_BUSY_CPU;
            r_lat_cnt   <= LAT_INIT;
            o_mem_read  <= ~i_cpu_we;
            o_mem_write <= i_cpu_we;
            o_mem_addr  <= i_cpu_addr;
            o_mem_wdata <= i_cpu_wdata;
            if (!i_ext_req) begin
              r_starve_cnt <= '0;
            end else if (r_starve_cnt != SC_MAX) begin
              r_starve_cnt <= r_starve_cnt + 1'b1;
            end
          end else if (i_ext_req) begin
            r_state      <= S_BUSY_EXT;
            r_lat_cnt    <= LAT_INIT;
            o_ext_gnt    <= 1'b1;
            o_mem_read   <= ~i_ext_we;
            o_mem_write  <= i_ext_we;
            o_mem_addr   <= i_ext_addr;
            o_mem_wdata  <= i_ext_wdata;
            r_starve_cnt <= '0;
          end else begin
            r_starve_cnt <= '0;
          end
        end
        S_BUSY_CPU, S_BUSY_EXT: begin
          if (r_lat_cnt == '0) begin
            if (o_mem_read) begin
              if (r_state == S_BUSY_CPU) begin
                o_cpu_rdata <= i_mem_rdata;
              end else begin
                o_ext_rdata <= i_mem_rdata;
              end
            end
            o_cpu_done  <= (r_state == S_BUSY_CPU);
            o_ext_done  <= (r_state == S_BUSY_EXT);
            o_ext_gnt   <= 1'b0;
            o_mem_read  <= 1'b0;
            o_mem_write <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            r_state     <= S_RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench: three arbiter instances (MEM_LAT = 2, 3, 1) against a fixed-pattern memory.
// Each task drives one scenario and compares against hand-derived cycle numbers and data.
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  logic reset;

  logic [2:0]       cpu_req, cpu_we, ext_req, ext_we;
  logic [2:0][63:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic [2:0]       cpu_stall, cpu_done, ext_gnt, ext_done, mem_read, mem_write;
  logic [2:0][63:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      // Memory contents: 0x10 holds 0xAB, every other address reads back addr ^ 0x12340000.
      assign mem_rdata[gi] = (mem_addr[gi] == 64'h10) ? 64'hAB : (mem_addr[gi] ^ 64'h1234_0000);
      dmem_port_arbiter #(
        .ADDR_W(64), .DATA_W(64),
        .MEM_LAT((gi == 0) ? 2 : ((gi == 1) ? 3 : 1)),
        .STARVE_MAX(4)
      ) u_dut (
        .clk(clk), .reset(reset),
        .i_cpu_req(cpu_req[gi]), .i_cpu_we(cpu_we[gi]),
        .i_cpu_addr(cpu_addr[gi]), .i_cpu_wdata(cpu_wdata[gi]),
        .o_cpu_stall(cpu_stall[gi]), .o_cpu_done(cpu_done[gi]), .o_cpu_rdata(cpu_rdata[gi]),
        .i_ext_req(ext_req[gi]), .i_ext_we(ext_we[gi]),
        .i_ext_addr(ext_addr[gi]), .i_ext_wdata(ext_wdata[gi]),
        .o_ext_gnt(ext_gnt[gi]), .o_ext_done(ext_done[gi]), .o_ext_rdata(ext_rdata[gi]),
        .o_mem_read(mem_read[gi]), .o_mem_write(mem_write[gi]),
        .o_mem_addr(mem_addr[gi]), .o_mem_wdata(mem_wdata[gi]), .i_mem_rdata(mem_rdata[gi])
      );
    end
  endgenerate

  logic [2:0] w_sc0;
  assign w_sc0 = g_dut[0].u_dut.r_starve_cnt;

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mem_read, mem_write, cpu_done, ext_done, ext_gnt, cpu_stall} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 0", {mem_read, mem_write, cpu_done, ext_done, ext_gnt, cpu_stall});
    end
    n_checks++;
    if ({cpu_rdata, ext_rdata, mem_addr, mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: data outputs not zero");
    end
    n_checks++;
    if (w_sc0 !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_starve: got %0d required 0", w_sc0);
    end
    reset = 1'b0;
    $display("txn reset released");
  endtask

  task automatic test_cpu_read();
    int done_c = -1;
    int rd_cycles = 0;
    bit stall_ok = 1'b1;
    repeat (2) @(negedge clk);
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 64'h10;
    #1;
    n_checks++;
    if (cpu_stall[0] !== 1'b1 || mem_read[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_read_t0: stall=%b mem_read=%b required 1/0", cpu_stall[0], mem_read[0]);
    end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (mem_read[0]) begin
        rd_cycles++;
        if (c > 2 || mem_addr[0] !== 64'h10) stall_ok = 1'b0;
      end
      if (c <= 2 && cpu_stall[0] !== 1'b1) stall_ok = 1'b0;
      if (cpu_done[0] && done_c < 0) begin
        done_c = c;
        if (cpu_stall[0] !== 1'b0) stall_ok = 1'b0;
        n_checks++;
        if (cpu_rdata[0] !== 64'hAB) begin
          n_fail++;
          $display("FAIL cpu_read_data: got %h required ab", cpu_rdata[0]);
        end
        cpu_req[0] = 1'b0;
      end
    end
    n_checks++;
    if (done_c !== 3 || rd_cycles !== 2) begin
      n_fail++;
      $display("FAIL cpu_read_timing: done at %0d, %0d read cycles; required 3, 2", done_c, rd_cycles);
    end
    n_checks++;
    if (!stall_ok) begin
      n_fail++;
      $display("FAIL cpu_read_stall: stall/addr pattern wrong, got bad required good");
    end
    $display("txn cpu read addr 10 rdata %h done cycle %0d", cpu_rdata[0], done_c);
  endtask

  task automatic test_arbitration();
    int cpu_done_c = -1;
    int gnt_c = -1;
    int ext_done_n = 0;
    repeat (2) @(negedge clk);
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 64'h18;
    ext_req[0] = 1'b1; ext_we[0] = 1'b0; ext_addr[0] = 64'h30;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (cpu_done[0]) begin
        if (cpu_done_c < 0) cpu_done_c = c;
        cpu_req[0] = 1'b0;
      end
      if (ext_gnt[0] && gnt_c < 0) gnt_c = c;
      if (ext_done[0]) begin
        ext_done_n++;
        ext_req[0] = 1'b0;
      end
    end
    n_checks++;
    if (cpu_done_c !== 3 || gnt_c !== 5) begin
      n_fail++;
      $display("FAIL arb_order: cpu_done %0d ext_gnt %0d, required 3 and 5", cpu_done_c, gnt_c);
    end
    n_checks++;
    if (ext_done_n !== 1) begin
      n_fail++;
      $display("FAIL arb_ext_done: got %0d pulses required 1", ext_done_n);
    end
    n_checks++;
    if (cpu_rdata[0] !== 64'h1234_0018 || ext_rdata[0] !== 64'h1234_0030) begin
      n_fail++;
      $display("FAIL arb_rdata: cpu %h ext %h required 12340018 12340030", cpu_rdata[0], ext_rdata[0]);
    end
    $display("txn contested cpu+ext reads: cpu %h ext %h", cpu_rdata[0], ext_rdata[0]);
  endtask

  task automatic test_starvation();
    int n_cpu = 0;
    int cpu_at_gnt = -1;
    int max_sc = 0;
    int sc_at_gnt = 7;
    logic stall_at_gnt = 1'b0;
    bit ext_seen = 1'b0;
    repeat (2) @(negedge clk);
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_addr[0] = 64'h40; cpu_wdata[0] = 64'h99;
    ext_req[0] = 1'b1; ext_we[0] = 1'b0; ext_addr[0] = 64'h50;
    for (int c = 1; c <= 40 && !ext_seen; c++) begin
      @(negedge clk);
      if (int'(w_sc0) > max_sc) max_sc = int'(w_sc0);
      if (cpu_done[0]) n_cpu++;
      if (ext_gnt[0] && cpu_at_gnt < 0) begin
        cpu_at_gnt = n_cpu;
        sc_at_gnt = int'(w_sc0);
        stall_at_gnt = cpu_stall[0];
      end
      if (ext_done[0]) begin
        ext_seen = 1'b1;
        cpu_req[0] = 1'b0;
        ext_req[0] = 1'b0;
      end
    end
    n_checks++;
    if (!ext_seen || cpu_at_gnt !== 4) begin
      n_fail++;
      $display("FAIL starve_count: cpu accesses before ext %0d (ext done %0b), required 4", cpu_at_gnt, ext_seen);
    end
    n_checks++;
    if (max_sc !== 4 || sc_at_gnt !== 0) begin
      n_fail++;
      $display("FAIL starve_cnt: max %0d at grant %0d, required 4 and 0", max_sc, sc_at_gnt);
    end
    n_checks++;
    if (stall_at_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL starve_stall: cpu_stall during ext access %b required 1", stall_at_gnt);
    end
    n_checks++;
    if (cpu_rdata[0] !== 64'h1234_0018 || ext_rdata[0] !== 64'h1234_0050) begin
      n_fail++;
      $display("FAIL starve_rdata: cpu %h ext %h required 12340018 12340050", cpu_rdata[0], ext_rdata[0]);
    end
    $display("txn starvation: %0d cpu writes then ext read %h", cpu_at_gnt, ext_rdata[0]);
  endtask

  task automatic test_ext_write();
    int wr_n = 0;
    int gnt_n = 0;
    int done_c = -1;
    bit fields_ok = 1'b1;
    bit cpu_seen = 1'b0;
    repeat (2) @(negedge clk);
    cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 64'h60;
    for (int c = 1; c <= 10 && !cpu_seen; c++) begin
      @(negedge clk);
      if (cpu_done[1]) begin
        cpu_seen = 1'b1;
        cpu_req[1] = 1'b0;
      end
    end
    n_checks++;
    if (!cpu_seen || cpu_rdata[1] !== 64'h1234_0060) begin
      n_fail++;
      $display("FAIL lat3_cpu_read: got %h (done %0b) required 12340060", cpu_rdata[1], cpu_seen);
    end
    repeat (2) @(negedge clk);
    ext_req[1] = 1'b1; ext_we[1] = 1'b1; ext_addr[1] = 64'h20; ext_wdata[1] = 64'h5A;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_read[1]) fields_ok = 1'b0;
      if (mem_write[1]) begin
        wr_n++;
        if (c > 3 || mem_addr[1] !== 64'h20 || mem_wdata[1] !== 64'h5A) fields_ok = 1'b0;
      end
      if (ext_gnt[1]) gnt_n++;
      if (ext_done[1] && done_c < 0) begin
        done_c = c;
        ext_req[1] = 1'b0;
      end
    end
    n_checks++;
    if (wr_n !== 3 || gnt_n !== 3 || done_c !== 4) begin
      n_fail++;
      $display("FAIL ext_write_timing: writes %0d gnt %0d done %0d, required 3 3 4", wr_n, gnt_n, done_c);
    end
    n_checks++;
    if (!fields_ok) begin
      n_fail++;
      $display("FAIL ext_write_fields: addr/wdata/enable pattern got bad required 20/5a write-only");
    end
    n_checks++;
    if (cpu_rdata[1] !== 64'h1234_0060 || ext_rdata[1] !== 64'h0) begin
      n_fail++;
      $display("FAIL ext_write_rdata: cpu %h ext %h required 12340060 0", cpu_rdata[1], ext_rdata[1]);
    end
    $display("txn ext write addr 20 data 5a done cycle %0d", done_c);
  endtask

  task automatic test_reset_mid_access();
    int wr_c = -1;
    int done_c = -1;
    repeat (2) @(negedge clk);
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_addr[0] = 64'h80; cpu_wdata[0] = 64'h77;
    @(negedge clk);
    n_checks++;
    if (mem_write[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre: mem_write %b required 1", mem_write[0]);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (mem_write[0] !== 1'b0 || cpu_done[0] !== 1'b0 || mem_addr[0] !== 64'h0 || cpu_rdata[0] !== 64'h0) begin
      n_fail++;
      $display("FAIL rst_mid_abort: mem_write %b done %b addr %h rdata %h required 0", mem_write[0], cpu_done[0], mem_addr[0], cpu_rdata[0]);
    end
    @(negedge clk);
    n_checks++;
    if (cpu_done[0] !== 1'b0 || mem_write[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_hold: done %b write %b required 0 0", cpu_done[0], mem_write[0]);
    end
    reset = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_write[0] && wr_c < 0) wr_c = c;
      if (cpu_done[0] && done_c < 0) begin
        done_c = c;
        cpu_req[0] = 1'b0;
      end
    end
    n_checks++;
    if (wr_c !== 1 || done_c !== 3) begin
      n_fail++;
      $display("FAIL rst_mid_restart: write at %0d done at %0d, required 1 and 3", wr_c, done_c);
    end
    $display("txn cpu write aborted by reset, re-issued done cycle %0d", done_c);
  endtask

  task automatic test_back_to_back();
    int n_done = 0;
    int last_c = -1;
    int first_c = -1;
    bit gap_ok = 1'b1;
    repeat (2) @(negedge clk);
    cpu_req[2] = 1'b1; cpu_we[2] = 1'b0; cpu_addr[2] = 64'h90;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (cpu_done[2]) begin
        n_done++;
        if (first_c < 0) first_c = c;
        if (last_c >= 0 && c - last_c != 3) gap_ok = 1'b0;
        last_c = c;
        if (c == 14) cpu_req[2] = 1'b0;
      end
    end
    cpu_req[2] = 1'b0;
    n_checks++;
    if (n_done !== 5 || first_c !== 2 || !gap_ok) begin
      n_fail++;
      $display("FAIL b2b_spacing: %0d dones first %0d gaps_ok %0b, required 5, 2, 1", n_done, first_c, gap_ok);
    end
    n_checks++;
    if (cpu_rdata[2] !== 64'h1234_0090) begin
      n_fail++;
      $display("FAIL b2b_rdata: got %h required 12340090", cpu_rdata[2]);
    end
    $display("txn back-to-back cpu reads: %0d completions", n_done);
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = '0; cpu_we = '0; ext_req = '0; ext_we = '0;
    cpu_addr = '0; cpu_wdata = '0; ext_addr = '0; ext_wdata = '0;
    test_reset();
    test_cpu_read();
    test_arbitration();
    test_starvation();
    test_ext_write();
    test_reset_mid_access();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
